// File: rtl/hwpe_ctrl_offload_master_if.sv
// HWPE peripheral control port: request channel driven by the initiator,
// grant and response channel driven by the accelerator configuration slave.
interface hwpe_ctrl_offload_master_if #(
  parameter int unsigned ID_WIDTH = 16
) ();
  logic                req_o;
  logic [31:0]         add_o;
  logic                we_n_o;
  logic [3:0]          be_o;
  logic [31:0]         data_o;
  logic [ID_WIDTH-1:0] id_o;
  logic                gnt_i;
  logic [31:0]         r_data_i;
  logic                r_valid_i;
  logic [ID_WIDTH-1:0] r_id_i;

  modport master (
    output req_o, add_o, we_n_o, be_o, data_o, id_o,
    input  gnt_i, r_data_i, r_valid_i, r_id_i
  );

  modport slave (
    input  req_o, add_o, we_n_o, be_o, data_o, id_o,
    output gnt_i, r_data_i, r_valid_i, r_id_i
  );
endinterface

// File: rtl/hwpe_ctrl_offload_master.sv
// HWPE offload initiator: ACQUIRE (with busy backoff), job register writes, TRIGGER, completion.
// Define HWPE_OFFLOAD_POLL_EN to detect completion by polling STATUS instead of evt_done_i.
module hwpe_ctrl_offload_master #(
  parameter int unsigned ID_WIDTH      = 16,
  parameter int unsigned CORE_ID       = 0,
  parameter int unsigned N_JOB_REGS    = 8,
  parameter logic [31:0] JOB_BASE_ADDR = 32'h40,
  parameter int unsigned RETRY_WAIT    = 4,
  parameter int unsigned POLL_INTERVAL = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                job_valid_i,
  output logic                                job_ready_o,
  input  logic [N_JOB_REGS-1:0][31:0]         job_data_i,
  input  logic [$clog2(N_JOB_REGS+1)-1:0]     job_nregs_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [7:0]                          job_id_o,
  input  logic                                evt_done_i,
  hwpe_ctrl_offload_master_if.master          periph
);

  localparam int unsigned NW = $clog2(N_JOB_REGS + 1);
  localparam int unsigned KW = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
  localparam logic [ID_WIDTH-1:0] ID_VAL = ID_WIDTH'(1) << CORE_ID;

  typedef enum logic [3:0] {
    IDLE, ACQ_REQ, ACQ_RSP, BACKOFF, WR_REQ, WR_RSP, TRIG_REQ, TRIG_RSP,
`ifdef HWPE_OFFLOAD_POLL_EN
    POLL_WAIT, POLL_REQ, POLL_RSP
`else
    WAIT_DONE
`endif
  } state_e;

  state_e                      state_q, state_d;
  logic [N_JOB_REGS-1:0][31:0] data_q, data_d;
  logic [NW-1:0]               nregs_q, nregs_d;
  logic [NW-1:0]               k_q, k_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [7:0]                  job_id_q, job_id_d;
  logic                        done_q, done_d;
  logic                        rsp_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      data_q   <= '0;
      nregs_q  <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      job_id_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      nregs_q  <= nregs_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      job_id_q <= job_id_d;
      done_q   <= done_d;
    end
  end

  assign rsp_ok = periph.r_valid_i && (periph.r_id_i == ID_VAL);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    nregs_d  = nregs_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    job_id_d = job_id_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (job_valid_i) begin
        data_d  = job_data_i;
        nregs_d = (job_nregs_i > NW'(N_JOB_REGS)) ? NW'(N_JOB_REGS) : job_nregs_i;
        k_d     = '0;
        state_d = ACQ_REQ;
      end
      ACQ_REQ: if (periph.gnt_i) state_d = ACQ_RSP;
      ACQ_RSP: if (rsp_ok) begin
        if (periph.r_data_i[31]) begin
          cnt_d   = '0;
          state_d = (RETRY_WAIT == 0) ? ACQ_REQ : BACKOFF;
        end else begin
          job_id_d = periph.r_data_i[7:0];
          state_d  = (nregs_q == '0) ? TRIG_REQ : WR_REQ;
        end
      end
      BACKOFF: begin
        if (cnt_q == 16'(RETRY_WAIT - 1)) state_d = ACQ_REQ;
        else                              cnt_d   = cnt_q + 16'd1;
      end
      WR_REQ: if (periph.gnt_i) state_d = WR_RSP;
      WR_RSP: if (rsp_ok) begin
        if (k_q + NW'(1) == nregs_q) begin
          state_d = TRIG_REQ;
        end else begin
          k_d     = k_q + NW'(1);
          state_d = WR_REQ;
        end
      end
      TRIG_REQ: if (periph.gnt_i) state_d = TRIG_RSP;
`ifdef HWPE_OFFLOAD_POLL_EN
      TRIG_RSP: if (rsp_ok) begin
        cnt_d   = '0;
        state_d = (POLL_INTERVAL == 0) ? POLL_REQ : POLL_WAIT;
      end
      POLL_WAIT: begin
        if (cnt_q == 16'(POLL_INTERVAL - 1)) state_d = POLL_REQ;
        else                                 cnt_d   = cnt_q + 16'd1;
      end
      POLL_REQ: if (periph.gnt_i) state_d = POLL_RSP;
      POLL_RSP: if (rsp_ok) begin
        cnt_d = '0;
        if (!periph.r_data_i[0]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = (POLL_INTERVAL == 0) ? POLL_REQ : POLL_WAIT;
        end
      end
`else
      TRIG_RSP: if (rsp_ok) state_d = WAIT_DONE;
      WAIT_DONE: if (evt_done_i) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Request fields decode from the registered state, so they hold until grant.
  logic        req;
  logic [31:0] add;
  logic        we_n;
  logic [3:0]  be;
  logic [31:0] wdata;

  always_comb begin
    req   = 1'b0;
    add   = '0;
    we_n  = 1'b1;
    be    = '0;
    wdata = '0;
    case (state_q)
      ACQ_REQ: begin
        req = 1'b1;
        add = 32'h04;
        be  = 4'hF;
      end
      WR_REQ: begin
        req   = 1'b1;
        add   = JOB_BASE_ADDR + (32'(k_q) << 2);
        we_n  = 1'b0;
        be    = 4'hF;
        wdata = data_q[k_q[KW-1:0]];
      end
      TRIG_REQ: begin
        req  = 1'b1;
        we_n = 1'b0;
        be   = 4'hF;
      end
`ifdef HWPE_OFFLOAD_POLL_EN
      POLL_REQ: begin
        req = 1'b1;
        add = 32'h0C;
        be  = 4'hF;
      end
`endif
      default: ;
    endcase
  end

  assign periph.req_o  = req;
  assign periph.add_o  = add;
  assign periph.we_n_o = we_n;
  assign periph.be_o   = be;
  assign periph.data_o = wdata;
  assign periph.id_o   = ID_VAL;

  assign job_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign job_id_o    = job_id_q;

  logic unused;
`ifdef HWPE_OFFLOAD_POLL_EN
  assign unused = ^{evt_done_i, periph.r_data_i[30:8]};
`else
  assign unused = ^{periph.r_data_i[30:8], POLL_INTERVAL == 0};
`endif

endmodule
